// File: rtl/str_ascii_to_int_if.sv
// Character-stream in / integer-result out handshake bundle for str_ascii_to_int.
// The master side is the character source plus the result consumer; the slave side is the converter.
interface str_ascii_to_int_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_char;
    logic             in_last;
    logic [1:0]       radix;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_value;
    logic             out_overflow;
    logic             out_stopped;
    logic [7:0]       out_ndigits;
    logic             out_toolong;

    modport master (
        output in_valid, in_char, in_last, radix, out_ready,
        input  in_ready, out_valid, out_value, out_overflow, out_stopped, out_ndigits, out_toolong
    );

    modport slave (
        input  in_valid, in_char, in_last, radix, out_ready,
        output in_ready, out_valid, out_value, out_overflow, out_stopped, out_ndigits, out_toolong
    );
endinterface

// File: rtl/str_ascii_to_int.sv
// Streaming atoi/atohex/atooct/atobin: one ASCII char per cycle in, one integer per string out.
// The result and its flags are held in OUT until the downstream stage accepts them.
module str_ascii_to_int #(
    parameter int WIDTH    = 32,
    parameter int MAXCHARS = 255
) (
    input logic               clk,
    input logic               rst,
    str_ascii_to_int_if.slave bus
);
    localparam int WW = WIDTH + 4;
    typedef logic [WW-1:0] wide_t;
    typedef enum logic [1:0] {IDLE, ACCUM, SKIP, OUT} state_t;

    state_t           state, state_n;
    logic [1:0]       radix_q, radix_n;
    logic [WIDTH-1:0] acc_q, acc_n;
    logic [WIDTH-1:0] value_q, value_n;
    logic             neg_q, neg_n;
    logic             ovf_q, ovf_n;
    logic             stop_q, stop_n;
    logic [7:0]       nd_q, nd_n;
    logic [8:0]       cnt_q, cnt_n;
    logic [4:0]       d;
    wide_t            wide;

    // Digit value of a character; 16 marks a non-digit so it fails every base test.
    function automatic logic [4:0] digit_val(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return 5'(c - 8'h30);
        if (c >= 8'h61 && c <= 8'h66) return 5'(c - 8'h61 + 8'd10);
        if (c >= 8'h41 && c <= 8'h46) return 5'(c - 8'h41 + 8'd10);
        return 5'd16;
    endfunction

    function automatic logic [4:0] base_of(input logic [1:0] r);
        case (r)
            2'd0:    return 5'd2;
            2'd1:    return 5'd8;
            2'd2:    return 5'd10;
            default: return 5'd16;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] x);
        return (x == 8'hFF) ? x : x + 8'd1;
    endfunction

    // The char counter only needs to distinguish "more than MAXCHARS" (MAXCHARS <= 255).
    function automatic logic [8:0] sat_cnt(input logic [8:0] x);
        return (x == 9'd256) ? x : x + 9'd1;
    endfunction

    always_comb begin
        state_n = state;
        radix_n = radix_q;
        acc_n   = acc_q;
        value_n = value_q;
        neg_n   = neg_q;
        ovf_n   = ovf_q;
        stop_n  = stop_q;
        nd_n    = nd_q;
        cnt_n   = cnt_q;
        d       = 5'd0;
        wide    = '0;
        case (state)
            OUT: begin
                if (bus.out_ready) state_n = IDLE;
            end
            default: begin
                if (bus.in_valid) begin
                    // The first char of a string starts from a clean slate and latches radix.
                    if (state == IDLE) begin
                        radix_n = bus.radix;
                        acc_n   = '0;
                        neg_n   = 1'b0;
                        ovf_n   = 1'b0;
                        stop_n  = 1'b0;
                        nd_n    = 8'd0;
                        cnt_n   = 9'd0;
                    end
                    cnt_n = sat_cnt(cnt_n);
                    if (state != SKIP) begin
                        state_n = ACCUM;
                        d       = digit_val(bus.in_char);
                        if (bus.in_char == 8'h5F) begin
                            state_n = ACCUM;
                        end else if ((bus.in_char == 8'h2D || bus.in_char == 8'h2B) &&
                                     state == IDLE && radix_n == 2'd2) begin
                            neg_n = (bus.in_char == 8'h2D);
                        end else if (d < base_of(radix_n)) begin
                            wide  = wide_t'(acc_n) * wide_t'(base_of(radix_n)) + wide_t'(d);
                            acc_n = wide[WIDTH-1:0];
                            ovf_n = ovf_n | (|wide[WW-1:WIDTH]);
                            nd_n  = sat_inc8(nd_n);
                        end else begin
                            stop_n  = 1'b1;
                            state_n = SKIP;
                        end
                    end
                    if (bus.in_last) begin
                        state_n = OUT;
                        value_n = neg_n ? -acc_n : acc_n;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            radix_q <= 2'd0;
            acc_q   <= '0;
            value_q <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            stop_q  <= 1'b0;
            nd_q    <= 8'd0;
            cnt_q   <= 9'd0;
        end else begin
            state   <= state_n;
            radix_q <= radix_n;
            acc_q   <= acc_n;
            value_q <= value_n;
            neg_q   <= neg_n;
            ovf_q   <= ovf_n;
            stop_q  <= stop_n;
            nd_q    <= nd_n;
            cnt_q   <= cnt_n;
        end
    end

    assign bus.in_ready     = (state != OUT);
    assign bus.out_valid    = (state == OUT);
    assign bus.out_value    = value_q;
    assign bus.out_overflow = ovf_q;
    assign bus.out_stopped  = stop_q;
    assign bus.out_ndigits  = nd_q;
    assign bus.out_toolong  = (cnt_q > 9'(MAXCHARS));
endmodule
